// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types for the hazard controller: forwarding-mux select codes and scoreboard states.
// Optional build feature: HAZ_PERF_CNT_EN adds the stall/flush perf counters.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic {
        MC_IDLE = 1'b0,
        MC_BUSY = 1'b1
    } mc_state_e;

    localparam int REG_AW_DEF   = 5;
    localparam int MC_LAT_W_DEF = 4;
    localparam int PERF_W_DEF   = 32;

endpackage

// File: rtl/hazard_ctrl_unit_if.sv
// Pipeline <-> hazard controller signal bundle. master = datapath side, slave = hazard controller.
// HAZ_PERF_CNT_EN adds the StallCnt/FlushCnt counters.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW   = 5,
    parameter int MC_LAT_W = 4,
    parameter int PERF_W   = 32
) ();
    logic [REG_AW-1:0]   Rs1_D;
    logic [REG_AW-1:0]   Rs2_D;
    logic                McOpD;
    logic [REG_AW-1:0]   Rs1_E;
    logic [REG_AW-1:0]   Rs2_E;
    logic [REG_AW-1:0]   RD_E;
    logic                LoadE;
    logic                PCSrcE;
    logic                McStartE;
    logic [MC_LAT_W-1:0] McLatE;
    logic                RegWriteM;
    logic [REG_AW-1:0]   RD_M;
    logic                RegWriteW;
    logic [REG_AW-1:0]   RD_W;
    logic [1:0]          ForwardAE;
    logic [1:0]          ForwardBE;
    logic                StallF;
    logic                StallD;
    logic                FlushD;
    logic                FlushE;
    logic                McBusy;
    logic                McDone;
    logic [REG_AW-1:0]   McRd;
`ifdef HAZ_PERF_CNT_EN
    logic [PERF_W-1:0]   StallCnt;
    logic [PERF_W-1:0]   FlushCnt;
`endif

    modport master (
`ifdef HAZ_PERF_CNT_EN
        input  StallCnt, FlushCnt,
`endif
        output Rs1_D, Rs2_D, McOpD, Rs1_E, Rs2_E, RD_E, LoadE, PCSrcE,
               McStartE, McLatE, RegWriteM, RD_M, RegWriteW, RD_W,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               McBusy, McDone, McRd
    );

    modport slave (
`ifdef HAZ_PERF_CNT_EN
        output StallCnt, FlushCnt,
`endif
        input  Rs1_D, Rs2_D, McOpD, Rs1_E, Rs2_E, RD_E, LoadE, PCSrcE,
               McStartE, McLatE, RegWriteM, RD_M, RegWriteW, RD_W,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
               McBusy, McDone, McRd
    );
endinterface

// File: rtl/hazard_ctrl_unit_chk.sv
// Simulation checker: a new multi-cycle op must never issue while the previous one is still running.
module hazard_ctrl_unit_chk (
    input logic clk,
    input logic rst,
    input logic mc_start,
    input logic mc_busy,
    input logic mc_done
);
    a_no_issue_while_busy: assert property (
        @(posedge clk) disable iff (rst) !(mc_start && mc_busy && !mc_done)
    ) else $error("multi-cycle issue while scoreboard busy");
endmodule

// File: rtl/hazard_ctrl_unit_mc_scoreboard.sv
// Single-entry scoreboard for one outstanding multi-cycle op: tracks its destination and
// counts down its latency, flagging completion in the final cycle.
module mc_scoreboard
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MC_LAT_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_start,
    input  logic [MC_LAT_W-1:0] i_lat,
    input  logic [REG_AW-1:0]   i_rd,
    output logic                o_busy,
    output logic                o_done,
    output logic [REG_AW-1:0]   o_rd
);
    localparam logic [MC_LAT_W-1:0] CNT_ONE  = {{(MC_LAT_W-1){1'b0}}, 1'b1};
    localparam logic [MC_LAT_W-1:0] CNT_ZERO = {MC_LAT_W{1'b0}};
    localparam logic [REG_AW-1:0]   RD_ZERO  = {REG_AW{1'b0}};

    mc_state_e           r_state, w_state_nxt;
    logic [MC_LAT_W-1:0] r_cnt, w_cnt_nxt;
    logic [REG_AW-1:0]   r_rd, w_rd_nxt;
    logic [MC_LAT_W-1:0] w_lat_eff;
    logic                w_done;

    // A zero latency still needs one cycle to complete.
    assign w_lat_eff = (i_lat == CNT_ZERO) ? CNT_ONE : i_lat;
    assign w_done    = (r_state == MC_BUSY) && (r_cnt == CNT_ONE);

    // State, countdown and destination registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MC_IDLE;
            r_cnt   <= CNT_ZERO;
            r_rd    <= RD_ZERO;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_rd    <= w_rd_nxt;
        end
    end

    // Next-state: issue loads the entry, completion either frees it or reloads back-to-back.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_rd_nxt    = r_rd;
        case (r_state)
            MC_IDLE: begin
                if (i_start) begin
                    w_state_nxt = MC_BUSY;
                    w_cnt_nxt   = w_lat_eff;
                    w_rd_nxt    = i_rd;
                end else begin
                    w_state_nxt = MC_IDLE;
                end
            end
            MC_BUSY: begin
                if (w_done && i_start) begin
                    w_cnt_nxt   = w_lat_eff;
                    w_rd_nxt    = i_rd;
                end else if (w_done) begin
                    w_state_nxt = MC_IDLE;
                    w_cnt_nxt   = CNT_ZERO;
                    w_rd_nxt    = RD_ZERO;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = MC_IDLE;
                w_cnt_nxt   = CNT_ZERO;
                w_rd_nxt    = RD_ZERO;
            end
        endcase
    end

    assign o_busy = (r_state == MC_BUSY);
    assign o_done = w_done;
    assign o_rd   = r_rd;
endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller for the 5-stage pipeline: E-stage forwarding, load-use / scoreboard / structural
// stalls and branch flushes. HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW   = 5,
    parameter int MC_LAT_W = 4,
    parameter int PERF_W   = 32
) (
    input logic              clk,
    input logic              rst,
    hazard_ctrl_unit_if.slave bus
);
    localparam logic [REG_AW-1:0] RD_ZERO = {REG_AW{1'b0}};

    logic              w_mc_busy, w_mc_done;
    logic [REG_AW-1:0] w_mc_rd;
    fwd_sel_e          w_fwd_a, w_fwd_b;
    logic              w_load_use, w_sb_hit, w_struct, w_stall;
    logic              w_stall_f, w_stall_d, w_flush_d, w_flush_e;

    function automatic fwd_sel_e fwd_pick(
        input logic [REG_AW-1:0] rs,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_w,
        input logic [REG_AW-1:0] rd_w
    );
        fwd_sel_e sel;
        if (we_m && (rd_m != RD_ZERO) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (we_w && (rd_w != RD_ZERO) && (rd_w == rs)) begin
            sel = FWD_WB;
        end else begin
            sel = FWD_RF;
        end
        return sel;
    endfunction

    mc_scoreboard #(.REG_AW(REG_AW), .MC_LAT_W(MC_LAT_W)) u_sb (
        .clk     (clk),
        .rst     (rst),
        .i_start (bus.McStartE),
        .i_lat   (bus.McLatE),
        .i_rd    (bus.RD_E),
        .o_busy  (w_mc_busy),
        .o_done  (w_mc_done),
        .o_rd    (w_mc_rd)
    );

    hazard_ctrl_unit_chk u_chk (
        .clk      (clk),
        .rst      (rst),
        .mc_start (bus.McStartE),
        .mc_busy  (w_mc_busy),
        .mc_done  (w_mc_done)
    );

    // Operand forwarding, forced to the register file while in reset.
    always_comb begin
        w_fwd_a = FWD_RF;
        w_fwd_b = FWD_RF;
        if (!rst) begin
            w_fwd_a = fwd_pick(bus.Rs1_E, bus.RegWriteM, bus.RD_M, bus.RegWriteW, bus.RD_W);
            w_fwd_b = fwd_pick(bus.Rs2_E, bus.RegWriteM, bus.RD_M, bus.RegWriteW, bus.RD_W);
        end else begin
            w_fwd_a = FWD_RF;
            w_fwd_b = FWD_RF;
        end
    end

    assign w_load_use = bus.LoadE && (bus.RD_E != RD_ZERO) &&
                        ((bus.RD_E == bus.Rs1_D) || (bus.RD_E == bus.Rs2_D));
    assign w_sb_hit   = w_mc_busy && !w_mc_done && (w_mc_rd != RD_ZERO) &&
                        ((w_mc_rd == bus.Rs1_D) || (w_mc_rd == bus.Rs2_D));
    assign w_struct   = bus.McOpD && w_mc_busy && !w_mc_done;
    assign w_stall    = w_load_use || w_sb_hit || w_struct;

    // Stall/flush merge; a taken branch discards the wrong-path D so it overrides any stall.
    always_comb begin
        w_stall_f = 1'b0;
        w_stall_d = 1'b0;
        w_flush_d = 1'b0;
        w_flush_e = 1'b0;
        if (rst) begin
            w_flush_e = 1'b0;
        end else if (bus.PCSrcE) begin
            w_flush_d = 1'b1;
            w_flush_e = 1'b1;
        end else begin
            w_stall_f = w_stall;
            w_stall_d = w_stall;
            w_flush_e = w_stall;
        end
    end

    assign bus.ForwardAE = w_fwd_a;
    assign bus.ForwardBE = w_fwd_b;
    assign bus.StallF    = w_stall_f;
    assign bus.StallD    = w_stall_d;
    assign bus.FlushD    = w_flush_d;
    assign bus.FlushE    = w_flush_e;
    assign bus.McBusy    = !rst && w_mc_busy;
    assign bus.McDone    = !rst && w_mc_done;
    assign bus.McRd      = rst ? RD_ZERO : w_mc_rd;

`ifdef HAZ_PERF_CNT_EN
    localparam logic [PERF_W-1:0] PERF_ONE = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0] PERF_MAX = {PERF_W{1'b1}};
    logic [PERF_W-1:0] r_stall_cnt, r_flush_cnt;

    // Saturating cycle counters for StallD and FlushE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= {PERF_W{1'b0}};
            r_flush_cnt <= {PERF_W{1'b0}};
        end else begin
            if (w_stall_d && (r_stall_cnt != PERF_MAX)) begin
                r_stall_cnt <= r_stall_cnt + PERF_ONE;
            end
            if (w_flush_e && (r_flush_cnt != PERF_MAX)) begin
                r_flush_cnt <= r_flush_cnt + PERF_ONE;
            end
        end
    end

    assign bus.StallCnt = rst ? {PERF_W{1'b0}} : r_stall_cnt;
    assign bus.FlushCnt = rst ? {PERF_W{1'b0}} : r_flush_cnt;
`endif
endmodule
